rr_vc_arbiter: RTL

Round-robin arbiter that drains four upstream virtual-channel FIFOs into one downstream FIFO. It sits directly downstream of the per-VC `fifo` instances, consuming their `Fifo_empty` / `Fifo_Data_out` / `valid_read` outputs and driving their `Fifo_rd`. It forwards each popped word to the downstream FIFO's write port, and stops issuing pops while the downstream FIFO's `pause` is high. It also tracks in-flight reads and flags protocol violations.

---
 rtl/vc_pkg.sv | 16 +
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_vc_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the virtual-channel arbiter: VC count, index type and
// arbiter state encoding.
package vc_pkg;

  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned VC_IDX_W = 2;

  typedef logic [VC_IDX_W-1:0] vc_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational priority rotator: first requester at or after start, scanning
// upward modulo four.
module rr_pick4
  import vc_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  vc_idx_t           start,
  output logic [NUM_VC-1:0] gnt_c,
  output vc_idx_t           idx_c,
  output logic              any_c
);

  vc_idx_t cand;

  always_comb begin
    gnt_c = '0;
    idx_c = start;
    any_c = 1'b0;
    cand  = start;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      cand = start + VC_IDX_W'(k);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_vc_arbiter.sv
// Round-robin drain of four upstream VC FIFOs into one downstream FIFO, with
// in-flight read tracking and a sticky protocol-error flag.
module rr_vc_arbiter
  import vc_pkg::*;
#(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned MAX_OUTST = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC-1:0]           vc_empty,
  input  logic [NUM_VC*BITNUMBER-1:0] vc_data,
  input  logic [NUM_VC-1:0]           vc_valid,
  input  logic                        ds_pause,
  input  logic                        ds_full,
  output logic [NUM_VC-1:0]           vc_pop,
  output logic [BITNUMBER-1:0]        ds_data,
  output logic                        ds_push,
  output vc_idx_t                     grant_ptr,
  output logic [1:0]                  outstanding,
  output logic                        proto_error,
  output logic [7:0]                  push_count
);

  localparam int unsigned OUT_W = 2;
  localparam int unsigned CNT_W = 8;

  arb_state_e           state_c;
  logic [NUM_VC-1:0]    req_c;
  logic [NUM_VC-1:0]    gnt_c;
  vc_idx_t              idx_c;
  logic                 any_c;
  logic                 pop_c;
  logic                 valid_any_c;
  logic                 valid_multi_c;
  logic                 valid_one_c;
  logic [BITNUMBER-1:0] valid_data_c;

  assign req_c = ~vc_empty;

  rr_pick4 u_pick (
    .req   (req_c),
    .start (grant_ptr),
    .gnt_c (gnt_c),
    .idx_c (idx_c),
    .any_c (any_c)
  );

  // Arbiter state follows the current-cycle inputs; HOLD outranks ACTIVE.
  always_comb begin
    state_c = ST_IDLE;
    if (ds_pause || ds_full) begin
      state_c = ST_HOLD;
    end else if (|req_c) begin
      state_c = ST_ACTIVE;
    end
  end

  assign pop_c  = (state_c == ST_ACTIVE) && (outstanding < OUT_W'(MAX_OUTST)) && any_c;
  assign vc_pop = pop_c ? gnt_c : '0;

  // Decode the returning read: a single valid bit selects its data slice.
  always_comb begin
    valid_data_c  = '0;
    valid_any_c   = |vc_valid;
    valid_multi_c = (vc_valid & (vc_valid - NUM_VC'(1))) != '0;
    valid_one_c   = valid_any_c && !valid_multi_c;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (vc_valid[i]) begin
        valid_data_c = vc_data[i*BITNUMBER +: BITNUMBER];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_ptr   <= '0;
      outstanding <= '0;
      ds_push     <= 1'b0;
      ds_data     <= '0;
      proto_error <= 1'b0;
      push_count  <= '0;
    end else begin
      if (pop_c) begin
        grant_ptr <= idx_c + VC_IDX_W'(1);
      end
      // A pop and a return on the same edge cancel; never underflow on a stray valid.
      if (pop_c && !valid_any_c) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!pop_c && valid_any_c && (outstanding != '0)) begin
        outstanding <= outstanding - OUT_W'(1);
      end
      ds_push <= valid_one_c;
      if (valid_one_c) begin
        ds_data    <= valid_data_c;
        push_count <= push_count + CNT_W'(1);
      end
      if (valid_multi_c || (valid_any_c && (outstanding == '0)) ||
          (pop_c && (outstanding >= OUT_W'(MAX_OUTST)))) begin
        proto_error <= 1'b1;
      end
    end
  end

endmodule
